// File: rtl/key_filter_pkg.sv
// -----------------------------------------------------------------------------
// key_filter_pkg
//   Shared constants for the push-button filter:
//   - 2-bit FSM state encodings (legacy-compatible localparams)
//   - default debounce / long-press windows for a 50 MHz sys_clk
// -----------------------------------------------------------------------------
package key_filter_pkg;

    typedef logic [1:0] key_fsm_t;

    localparam key_fsm_t IDLE       = 2'd0;
    localparam key_fsm_t PRESS_FILT = 2'd1;
    localparam key_fsm_t DOWN       = 2'd2;
    localparam key_fsm_t REL_FILT   = 2'd3;

    // 20 ms and 1 s at 50 MHz
    localparam logic [19:0] CNT_MAX_DEF  = 20'd999_999;
    localparam logic [25:0] LONG_MAX_DEF = 26'd49_999_999;

endpackage

// File: rtl/key_filter_if.sv
// -----------------------------------------------------------------------------
// key_filter_if
//   Button-side signal bundle of the key filter.
//   key_in    : raw active-low button (asynchronous)
//   key_flag  : one-cycle pulse on confirmed press
//   rel_flag  : one-cycle pulse on confirmed release
//   long_flag : one-cycle pulse once per press after the long-hold time
//   key_state : debounced level, 1 = released, 0 = pressed
//   modport slave  : the filter itself (consumes key_in, produces events)
//   modport master : the environment driving the button and using the events
// -----------------------------------------------------------------------------
interface key_filter_if;

    logic key_in;
    logic key_flag;
    logic rel_flag;
    logic long_flag;
    logic key_state;

    modport master (
        output key_in,
        input  key_flag,
        input  rel_flag,
        input  long_flag,
        input  key_state
    );

    modport slave (
        input  key_in,
        output key_flag,
        output rel_flag,
        output long_flag,
        output key_state
    );

endinterface

// File: rtl/key_filter_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//   1-bit two-flop synchroniser for asynchronous inputs.
//   Both stages reset to 1 (idle level of an active-low button).
//   sys_clk   : destination clock
//   sys_rst_n : asynchronous active-low reset
//   d         : asynchronous input
//   q         : synchronised output (second stage)
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic d,
    output logic q
);

    logic s1;
    logic s2;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= d;
            s2 <= s1;
        end
    end

    assign q = s2;

endmodule

// File: rtl/key_filter.sv
// -----------------------------------------------------------------------------
// key_filter
//   Debounces one active-low push-button and produces single-cycle press,
//   release and long-press pulses plus a stable debounced level.
//   Parameters:
//     CNT_MAX  : debounce window in clocks (2 .. 2^20-1)
//     LONG_MAX : hold time after the press pulse before long_flag (> CNT_MAX)
//   Ports:
//     sys_clk   : system clock
//     sys_rst_n : asynchronous active-low reset
//     key_bus   : key_filter_if.slave (key_in in; key_flag, rel_flag,
//                 long_flag, key_state out)
// -----------------------------------------------------------------------------
module key_filter
    import key_filter_pkg::*;
#(
    parameter logic [19:0] CNT_MAX  = CNT_MAX_DEF,
    parameter logic [25:0] LONG_MAX = LONG_MAX_DEF
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    key_filter_if.slave  key_bus
);

    logic        s2;
    key_fsm_t    state;
    logic [19:0] fcnt;
    logic [25:0] lcnt;
    logic        long_done;
    logic        key_flag_r;
    logic        rel_flag_r;
    logic        long_flag_r;
    logic        key_state_r;

    sync_2ff u_sync (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .d         (key_bus.key_in),
        .q         (s2)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= IDLE;
            fcnt        <= '0;
            lcnt        <= '0;
            long_done   <= 1'b0;
            key_flag_r  <= 1'b0;
            rel_flag_r  <= 1'b0;
            long_flag_r <= 1'b0;
            key_state_r <= 1'b1;
        end else begin
            // Flags are pulses: low unless a branch below raises them.
            key_flag_r  <= 1'b0;
            rel_flag_r  <= 1'b0;
            long_flag_r <= 1'b0;

            case (state)
                IDLE: begin
                    if (!s2) begin
                        state <= PRESS_FILT;
                        fcnt  <= '0;
                    end
                end
                PRESS_FILT: begin
                    if (s2) begin
                        state <= IDLE;
                    end else if (fcnt == CNT_MAX - 20'd1) begin
                        state       <= DOWN;
                        key_flag_r  <= 1'b1;
                        key_state_r <= 1'b0;
                        lcnt        <= '0;
                    end else begin
                        fcnt <= fcnt + 20'd1;
                    end
                end
                DOWN: begin
                    // lcnt freezes once long_flag has fired, so it never wraps.
                    if (s2) begin
                        state <= REL_FILT;
                        fcnt  <= '0;
                    end else if (lcnt == LONG_MAX - 26'd1 && !long_done) begin
                        long_flag_r <= 1'b1;
                        long_done   <= 1'b1;
                    end else if (!long_done) begin
                        lcnt <= lcnt + 26'd1;
                    end
                end
                REL_FILT: begin
                    // A release bounce resumes the hold with lcnt/long_done intact.
                    if (!s2) begin
                        state <= DOWN;
                    end else if (fcnt == CNT_MAX - 20'd1) begin
                        state       <= IDLE;
                        rel_flag_r  <= 1'b1;
                        key_state_r <= 1'b1;
                        long_done   <= 1'b0;
                    end else begin
                        fcnt <= fcnt + 20'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign key_bus.key_flag  = key_flag_r;
    assign key_bus.rel_flag  = rel_flag_r;
    assign key_bus.long_flag = long_flag_r;
    assign key_bus.key_state = key_state_r;

endmodule

// File: tb/tb_key_filter.sv
module tb_key_filter;
    import key_filter_pkg::*;

    localparam int KEY_EV  = 0;
    localparam int REL_EV  = 1;
    localparam int LONG_EV = 2;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    typedef struct {
        int low_len;    // cycles key_in held low, then 12 cycles high
        int key_edge;   // expected edge index of key_flag (-1 = none)
        int long_edge;  // expected edge index of long_flag (-1 = none)
        int rel_edge;   // expected edge index of rel_flag (-1 = none)
        int mid_state;  // key_state two edges after key_in returns high
    } vec_t;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    ev_t  sb[$];

    key_filter_if kif ();

    key_filter #(
        .CNT_MAX  (20'd4),
        .LONG_MAX (26'd20)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key_bus   (kif)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc++;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (cyc %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_ev(input int kind, input int t0, input int edge_idx);
        ev_t e;
        if (edge_idx >= 0) begin
            e.kind = kind;
            e.cyc  = t0 + 1 + edge_idx;
            sb.push_back(e);
        end
    endtask

    task automatic pop_check(input int kind);
        ev_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_flag actual kind=%0d at cyc %0d required none", kind, cyc);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.cyc != cyc) begin
                bad++;
                $display("FAIL flag_event actual kind=%0d cyc=%0d required kind=%0d cyc=%0d",
                         kind, cyc, e.kind, e.cyc);
            end
        end
    endtask

    // Output monitor: every flag pulse must match the head of the scoreboard.
    always @(negedge sys_clk) begin
        int n;
        n = int'(kif.key_flag) + int'(kif.rel_flag) + int'(kif.long_flag);
        if (n > 0) chk("flags_exclusive", (n > 1) ? 1 : 0, 0);
        if (kif.key_flag)  pop_check(KEY_EV);
        if (kif.long_flag) pop_check(LONG_EV);
        if (kif.rel_flag)  pop_check(REL_EV);
    end

    task automatic run_vec(input vec_t v);
        int t0;
        t0 = cyc;
        push_ev(KEY_EV,  t0, v.key_edge);
        push_ev(LONG_EV, t0, v.long_edge);
        push_ev(REL_EV,  t0, v.rel_edge);
        kif.key_in = 1'b0;
        repeat (v.low_len) @(negedge sys_clk);
        kif.key_in = 1'b1;
        repeat (2) @(negedge sys_clk);
        chk($sformatf("mid_state_L%0d", v.low_len), int'(kif.key_state), v.mid_state);
        repeat (10) @(negedge sys_clk);
        chk($sformatf("end_state_L%0d", v.low_len), int'(kif.key_state), 1);
        chk($sformatf("end_idle_L%0d", v.low_len), int'(dut.state), int'(IDLE));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[7];
        int   t0;

        // Press confirmed at edge 6 needs L >= 5; long_flag needs L >= 25.
        vecs[0] = '{3,  -1, -1, -1, 1};
        vecs[1] = '{4,  -1, -1, -1, 1};
        vecs[2] = '{5,   6, -1, 11, 0};
        vecs[3] = '{10,  6, -1, 16, 0};
        vecs[4] = '{24,  6, -1, 30, 0};
        vecs[5] = '{25,  6, 26, 31, 0};
        vecs[6] = '{40,  6, 26, 46, 0};

        kif.key_in = 1'b1;
        sys_rst_n  = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("rst_key_state", int'(kif.key_state), 1);
        chk("rst_key_flag",  int'(kif.key_flag),  0);
        chk("rst_rel_flag",  int'(kif.rel_flag),  0);
        chk("rst_long_flag", int'(kif.long_flag), 0);
        chk("rst_fsm",       int'(dut.state),     int'(IDLE));
        sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Bounce: low 3, high 2, low 3, then high -> nothing.
        kif.key_in = 1'b0;
        repeat (3) @(negedge sys_clk);
        kif.key_in = 1'b1;
        repeat (2) @(negedge sys_clk);
        kif.key_in = 1'b0;
        repeat (3) @(negedge sys_clk);
        kif.key_in = 1'b1;
        repeat (12) @(negedge sys_clk);
        chk("bounce_state", int'(kif.key_state), 1);
        chk("bounce_idle",  int'(dut.state),     int'(IDLE));

        // Release bounce: key at 6, REL_FILT at 12..13, back to DOWN at 14,
        // lcnt held at 5 so long_flag lands 3 edges later at 29.
        t0 = cyc;
        push_ev(KEY_EV,  t0, 6);
        push_ev(LONG_EV, t0, 29);
        push_ev(REL_EV,  t0, 46);
        kif.key_in = 1'b0;
        repeat (10) @(negedge sys_clk);
        kif.key_in = 1'b1;
        repeat (2) @(negedge sys_clk);
        kif.key_in = 1'b0;
        repeat (2) @(negedge sys_clk);
        chk("relb_state_in_filt", int'(kif.key_state), 0);
        chk("relb_fsm_filt",      int'(dut.state),     int'(REL_FILT));
        repeat (1) @(negedge sys_clk);
        chk("relb_fsm_down",      int'(dut.state),     int'(DOWN));
        chk("relb_lcnt_kept",     int'(dut.lcnt),      5);
        repeat (25) @(negedge sys_clk);
        kif.key_in = 1'b1;
        repeat (12) @(negedge sys_clk);
        chk("relb_end_state", int'(kif.key_state), 1);

        // Reset while held in DOWN: no rel_flag, fresh key_flag after reset.
        t0 = cyc;
        push_ev(KEY_EV, t0, 6);
        push_ev(KEY_EV, t0, 19);
        push_ev(REL_EV, t0, 31);
        kif.key_in = 1'b0;
        repeat (11) @(negedge sys_clk);
        chk("pre_rst_state", int'(kif.key_state), 0);
        sys_rst_n = 1'b0;
        #1;
        chk("async_rst_key_state", int'(kif.key_state), 1);
        chk("async_rst_fsm",       int'(dut.state),     int'(IDLE));
        chk("async_rst_lcnt",      int'(dut.lcnt),      0);
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (12) @(negedge sys_clk);
        chk("post_rst_state", int'(kif.key_state), 0);
        kif.key_in = 1'b1;
        repeat (12) @(negedge sys_clk);
        chk("post_rst_end_state", int'(kif.key_state), 1);

        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
